// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshake signals and data-memory bus for mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters plus the data memory, as driven by the surrounding system.
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output gnt0, gnt1, done0, done1, rdata0, rdata1,
    output mem_write, mem_read, mem_address, mem_write_data, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1,
    input  mem_write, mem_read, mem_address, mem_write_data, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Optional build macro MEM_ARB_FIXED_PRI_EN: when defined, requester 0 wins
// simultaneous requests; otherwise ties are broken round-robin via last_winner.
module mem_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              win;        // 0 = requester 0 owns the current access
  logic              win_nxt;
  logic              take;       // command accepted at this edge
  logic              pick_win;   // winner if a command is accepted now
  logic              lat_we;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rd_word;

  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

`ifdef MEM_ARB_FIXED_PRI_EN
  // Requester 0 wins every tie; requester 1 only wins when alone.
  assign pick_win = ~bus.req0;
`else
  logic last_winner;

  assign pick_win = (bus.req0 & bus.req1) ? ~last_winner : bus.req1;

  // Remember who was served last so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner <= 1'b1;
    end else if (take) begin
      last_winner <= pick_win;
    end
  end
`endif

  // State and current-owner register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      win   <= 1'b0;
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
    end
  end

  // Next-state decode and per-state output strobes.
  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    take      = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          take      = 1'b1;
          win_nxt   = pick_win;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        gnt0      = ~win;
        gnt1      = win;
        mem_write = lat_we;
        mem_read  = ~lat_we;
        state_nxt = RESP;
      end
      RESP: begin
        done0 = ~win;
        done1 = win;
        if (!lat_we) begin
          if (win) rdata1 = rd_word;
          else     rdata0 = rd_word;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch; the memory bus keeps showing the last accepted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (take) begin
      lat_we  <= pick_win ? bus.we1    : bus.we0;
      addr_r  <= pick_win ? bus.addr1  : bus.addr0;
      wdata_r <= pick_win ? bus.wdata1 : bus.wdata0;
    end
  end

  // Read word captured at the edge that ends a read ACCESS; only shown in RESP.
  always_ff @(posedge clk) begin
    if (state == ACCESS && !lat_we) begin
      rd_word <= bus.mem_read_data;
    end
  end

  assign bus.gnt0           = gnt0;
  assign bus.gnt1           = gnt1;
  assign bus.done0          = done0;
  assign bus.done1          = done1;
  assign bus.rdata0         = rdata0;
  assign bus.rdata1         = rdata1;
  assign bus.mem_write      = mem_write;
  assign bus.mem_read       = mem_read;
  assign bus.mem_address    = addr_r;
  assign bus.mem_write_data = wdata_r;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-timing reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory: 16 words, cleared by reset, written on the write strobe.
  logic [31:0] tbmem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= 32'd0;
    end else if (bus.mem_write) begin
      tbmem[bus.mem_address[5:2]] <= bus.mem_write_data;
    end
  end
  assign bus.mem_read_data = tbmem[bus.mem_address[5:2]];

  int errors = 0;
  int checks = 0;

  // Reference model: tracks the edge at which the last command was accepted.
  // The command owns the bus for the cycle after acceptance (gnt + strobe)
  // and reports completion the cycle after that (done).
  int          cyc     = 0;
  int          acc_cyc = -100;
  bit          m_win   = 1'b0;
  bit          m_we    = 1'b0;
  bit          m_last  = 1'b1;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] ref_mem [16];

  task automatic model_edge(input bit rs, input bit r0, input bit r1,
                            input bit w0, input bit w1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1);
    int pre;
    pre = cyc - acc_cyc;
    cyc++;
    if (rs) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
      acc_cyc = -100;
      m_addr  = 32'd0;
      m_wdata = 32'd0;
      m_last  = 1'b1;
    end else begin
      if (pre == 0) begin
        if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
        else      m_rdata = ref_mem[m_addr[5:2]];
      end
      if (pre >= 2 && (r0 || r1)) begin
        if (r0 && r1) begin
`ifdef MEM_ARB_FIXED_PRI_EN
          m_win = 1'b0;
`else
          m_win = ~m_last;
`endif
        end else begin
          m_win = r1;
        end
        m_last  = m_win;
        acc_cyc = cyc;
        m_we    = m_win ? w1 : w0;
        m_addr  = m_win ? a1 : a0;
        m_wdata = m_win ? d1 : d0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int d;
    bit acc;
    bit rsp;
    d   = cyc - acc_cyc;
    acc = (d == 0);
    rsp = (d == 1);
    chk("gnt0",      32'(bus.gnt0),      32'(acc && !m_win));
    chk("gnt1",      32'(bus.gnt1),      32'(acc && m_win));
    chk("mem_write", 32'(bus.mem_write), 32'(acc && m_we));
    chk("mem_read",  32'(bus.mem_read),  32'(acc && !m_we));
    chk("done0",     32'(bus.done0),     32'(rsp && !m_win));
    chk("done1",     32'(bus.done1),     32'(rsp && m_win));
    chk("rdata0",    bus.rdata0, (rsp && !m_win && !m_we) ? m_rdata : 32'd0);
    chk("rdata1",    bus.rdata1, (rsp && m_win && !m_we) ? m_rdata : 32'd0);
    chk("mem_address",    bus.mem_address,    m_addr);
    chk("mem_write_data", bus.mem_write_data, m_wdata);
    chk("busy",      32'(bus.busy),      32'(acc || rsp));
  endtask

  // One clock: capture inputs seen at the edge, advance model, compare outputs.
  task automatic cycle();
    bit rs, r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    rs = reset; r0 = bus.req0; r1 = bus.req1; w0 = bus.we0; w1 = bus.we1;
    a0 = bus.addr0; a1 = bus.addr1; d0 = bus.wdata0; d1 = bus.wdata1;
    @(posedge clk);
    #1;
    model_edge(rs, r0, r1, w0, w1, a0, a1, d0, d1);
    check_all();
  endtask

  int g0;
  int g1;

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 32'd0; bus.addr1 = 32'd0; bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;

    // Reset state
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Write 0x5 to 0x8 from requester 0
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h8; bus.wdata0 = 32'h5;
    cycle();
    chk("wr_gnt0", 32'(bus.gnt0), 32'd1);
    chk("wr_addr", bus.mem_address, 32'h8);
    bus.req0 = 1'b0;
    cycle();
    chk("wr_done0", 32'(bus.done0), 32'd1);
    chk("mem_word2", tbmem[2], 32'h5);
    cycle();

    // Read back 0x8 from requester 1
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h8;
    cycle();
    chk("rd_strobe", 32'(bus.mem_read), 32'd1);
    bus.req1 = 1'b0;
    cycle();
    chk("rd_rdata1", bus.rdata1, 32'h5);
    chk("rd_rdata0", bus.rdata0, 32'h0);
    cycle();

    // Both requesters held high
    g0 = 0; g1 = 0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h8;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h13; bus.wdata1 = 32'hCAFE;
    for (int i = 0; i < 12; i++) begin
      cycle();
      g0 += int'(bus.gnt0);
      g1 += int'(bus.gnt1);
    end
`ifdef MEM_ARB_FIXED_PRI_EN
    chk("tie_gnt0_count", g0, 4);
    chk("tie_gnt1_count", g1, 0);
`else
    chk("tie_gnt0_count", g0, 2);
    chk("tie_gnt1_count", g1, 2);
`endif
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cycle();
    cycle();
    cycle();

    // Reset during ACCESS of a write to 0xC
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'hC; bus.wdata0 = 32'hAB;
    cycle();
    chk("abort_gnt0", 32'(bus.gnt0), 32'd1);
    reset = 1'b1; bus.req0 = 1'b0;
    cycle();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_addr", bus.mem_address, 32'd0);
    reset = 1'b0;
    cycle();
    chk("abort_no_done", 32'(bus.done0), 32'd0);

    // Ten idle cycles
    for (int i = 0; i < 10; i++) cycle();

    // Random traffic; requesters hold their command until granted
    for (int i = 0; i < 600; i++) begin
      if (bus.gnt0) begin
        bus.req0 = 1'($urandom_range(0, 1));
        bus.we0 = 1'($urandom_range(0, 1)); bus.addr0 = $urandom; bus.wdata0 = $urandom;
      end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1;
        bus.we0 = 1'($urandom_range(0, 1)); bus.addr0 = $urandom; bus.wdata0 = $urandom;
      end
      if (bus.gnt1) begin
        bus.req1 = 1'($urandom_range(0, 1));
        bus.we1 = 1'($urandom_range(0, 1)); bus.addr1 = $urandom; bus.wdata1 = $urandom;
      end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1;
        bus.we1 = 1'($urandom_range(0, 1)); bus.addr1 = $urandom; bus.wdata1 = $urandom;
      end
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
